// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared encodings for the ALU sequencer (ALU functions, command codes, FSM states).
package alu_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4, ALU_SHL = 3'd5, ALU_SHR = 3'd6, ALU_PASS = 3'd7;
    localparam logic [3:0] OP_LOAD = 4'd8, OP_MUL = 4'd9;
endpackage

// File: rtl/alu_sequencer_acc_flag_reg.sv
// acc_flag_reg: accumulator plus V/Z/C flags, loaded on commit enable, synchronously cleared.
module acc_flag_reg #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [n-1:0] d,
    input  logic         v_d,
    input  logic         z_d,
    input  logic         c_d,
    output logic [n-1:0] q,
    output logic         v,
    output logic         z,
    output logic         c
);
    always_ff @(posedge clk) begin
        if (rst) {q, v, z, c} <= '0;
        else if (en) {q, v, z, c} <= {d, v_d, z_d, c_d};
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: command sequencer driving an external ALU, owning the accumulator and flags.
// Define ALU_SEQ_MUL_EN to add the shift-and-add multiply command (op_code 9).
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [3:0]   op_code,
    input  logic [n-1:0] op_data,
    output logic [2:0]   alu_cntrl,
    output logic [n-1:0] alu_in1,
    output logic [n-1:0] alu_in2,
    input  logic [n-1:0] alu_out,
    input  logic         alu_V,
    input  logic         alu_Z,
    input  logic         alu_cout,
    output logic [n-1:0] acc,
    output logic         flag_V,
    output logic         flag_Z,
    output logic         flag_C,
    output logic         done,
    output logic         illegal
);
    state_t state, state_nx;
    logic [3:0] code;
    logic [n-1:0] data, acc_d;
    logic accept, legal, commit, v_d, z_d, c_d;
    assign op_ready = state == IDLE;
    assign accept = op_valid && op_ready;
`ifdef ALU_SEQ_MUL_EN
    localparam int IW = n > 1 ? $clog2(n) : 1;
    logic [IW-1:0] i;
    logic [n-1:0] p, p_nx;
    logic [2*n-1:0] shifted;
    logic ovf, ovf_nx, last;
    assign legal = op_code <= OP_MUL;
    assign shifted = {{n{1'b0}}, acc} << i;
    assign last = i == IW'(n - 1);
    assign p_nx = data[i] ? alu_out : p;
    // Overflow covers both the adder carry and multiplicand bits pushed past the top by the shift.
    assign ovf_nx = ovf || (data[i] && (alu_cout || |shifted[2*n-1:n]));
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            p <= '0;
            i <= '0;
            ovf <= 1'b0;
        end else if (state == MUL) begin
            p <= p_nx;
            i <= i + 1'b1;
            ovf <= ovf_nx;
        end
    end
`else
    assign legal = op_code <= OP_LOAD;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            code <= '0;
            data <= '0;
            done <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            done <= commit;
            illegal <= accept && !legal;
            if (accept) begin
                code <= op_code;
                data <= op_data;
            end
        end
    end
    always_comb begin
        state_nx = state;
        alu_cntrl = ALU_PASS;
        alu_in1 = acc;
        alu_in2 = '0;
        commit = 1'b0;
        acc_d = alu_out;
        v_d = alu_V;
        z_d = alu_Z;
        c_d = alu_cout;
        case (state)
`ifdef ALU_SEQ_MUL_EN
            IDLE: if (accept && legal) state_nx = (op_code == OP_MUL) ? MUL : EXEC;
`else
            IDLE: if (accept && legal) state_nx = EXEC;
`endif
            EXEC: begin
                alu_cntrl = code[2:0];
                alu_in2 = data;
                commit = 1'b1;
                state_nx = IDLE;
                if (code == OP_LOAD) begin
                    acc_d = data;
                    v_d = 1'b0;
                    z_d = data == '0;
                    c_d = 1'b0;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                alu_cntrl = ALU_ADD;
                alu_in1 = p;
                alu_in2 = shifted[n-1:0];
                acc_d = p_nx;
                v_d = 1'b0;
                z_d = p_nx == '0;
                c_d = ovf_nx;
                commit = last;
                state_nx = last ? IDLE : MUL;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end
    acc_flag_reg #(.n(n)) u_acc (
        .clk(clk),
        .rst(rst),
        .en (commit),
        .d  (acc_d),
        .v_d(v_d),
        .z_d(z_d),
        .c_d(c_d),
        .q  (acc),
        .v  (flag_V),
        .z  (flag_Z),
        .c  (flag_C)
    );
endmodule
